// File: rtl/hamming_secded_enlace.sv
// SEC-DED Hamming(8,4) link: encode, channel corruption, syndrome, correct.
// Three register stages; one word accepted per clock with no back-pressure.
module hamming_secded_enlace (
  input  logic       reloj,
  input  logic       reinicio_n,
  input  logic [3:0] dato_entrada,
  input  logic [3:0] dato_error,
  output logic [7:0] palabra,
  output logic [7:0] recibido,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       st,
  output logic       error_simple,
  output logic       error_doble,
  output logic [3:0] corregido,
  output logic [7:0] palabra_corregida,
  output logic       simplerror_detectado,
  output logic       doblerror_detectado,
  output logic       led_doblerror
);

  // Codeword bit i is Hamming position i; bit 0 holds overall parity.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] w;
    w      = '0;
    w[3]   = d[0];
    w[5]   = d[1];
    w[6]   = d[2];
    w[7]   = d[3];
    w[1]   = d[0] ^ d[1] ^ d[3];
    w[2]   = d[0] ^ d[2] ^ d[3];
    w[4]   = d[1] ^ d[2] ^ d[3];
    w[0]   = ^w[7:1];
    return w;
  endfunction

  // Stage 1 state
  logic [7:0] palabra_q, palabra_d;
  logic [3:0] dato_error_q, dato_error_d;

  // Stage 2 state
  logic [7:0] recibido_q, recibido_d;
  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic       st_q, st_d;
  logic       error_simple_q, error_simple_d;
  logic       error_doble_q, error_doble_d;

  // Stage 3 state
  logic [7:0] palabra_corregida_q, palabra_corregida_d;
  logic [3:0] corregido_q, corregido_d;
  logic       simplerror_q, simplerror_d;
  logic       doblerror_q, doblerror_d;
  logic       led_q, led_d;

  logic [2:0] syn_q;
  logic [7:0] flip_mask;

  always_comb begin
    palabra_d    = encode(dato_entrada);
    dato_error_d = dato_error;
  end

  // Channel model overwrites the data positions; parity bits travel intact.
  always_comb begin
    recibido_d     = {dato_error_q[3], dato_error_q[2], dato_error_q[1], palabra_q[4],
                      dato_error_q[0], palabra_q[2:0]};
    s1_d           = recibido_d[1] ^ recibido_d[3] ^ recibido_d[5] ^ recibido_d[7];
    s2_d           = recibido_d[2] ^ recibido_d[3] ^ recibido_d[6] ^ recibido_d[7];
    s3_d           = recibido_d[4] ^ recibido_d[5] ^ recibido_d[6] ^ recibido_d[7];
    st_d           = ^recibido_d;
    error_simple_d = st_d;
    error_doble_d  = !st_d && ({s3_d, s2_d, s1_d} != 3'b000);
  end

  assign syn_q = {s3_q, s2_q, s1_q};

  // A zero syndrome with odd parity means p0 itself flipped, so the shift lands on bit 0.
  always_comb begin
    flip_mask = 8'h00;
    if (error_simple_q) begin
      flip_mask = 8'h01 << syn_q;
    end
    palabra_corregida_d = recibido_q ^ flip_mask;
    corregido_d         = {palabra_corregida_d[7], palabra_corregida_d[6],
                           palabra_corregida_d[5], palabra_corregida_d[3]};
    simplerror_d        = error_simple_q;
    doblerror_d         = error_doble_q;
    led_d               = error_doble_q;
  end

  always_ff @(posedge reloj or negedge reinicio_n) begin
    if (!reinicio_n) begin
      palabra_q           <= '0;
      dato_error_q        <= '0;
      recibido_q          <= '0;
      s1_q                <= 1'b0;
      s2_q                <= 1'b0;
      s3_q                <= 1'b0;
      st_q                <= 1'b0;
      error_simple_q      <= 1'b0;
      error_doble_q       <= 1'b0;
      palabra_corregida_q <= '0;
      corregido_q         <= '0;
      simplerror_q        <= 1'b0;
      doblerror_q         <= 1'b0;
      led_q               <= 1'b0;
    end else begin
      palabra_q           <= palabra_d;
      dato_error_q        <= dato_error_d;
      recibido_q          <= recibido_d;
      s1_q                <= s1_d;
      s2_q                <= s2_d;
      s3_q                <= s3_d;
      st_q                <= st_d;
      error_simple_q      <= error_simple_d;
      error_doble_q       <= error_doble_d;
      palabra_corregida_q <= palabra_corregida_d;
      corregido_q         <= corregido_d;
      simplerror_q        <= simplerror_d;
      doblerror_q         <= doblerror_d;
      led_q               <= led_d;
    end
  end

  assign palabra              = palabra_q;
  assign recibido             = recibido_q;
  assign s1                   = s1_q;
  assign s2                   = s2_q;
  assign s3                   = s3_q;
  assign st                   = st_q;
  assign error_simple         = error_simple_q;
  assign error_doble          = error_doble_q;
  assign corregido            = corregido_q;
  assign palabra_corregida    = palabra_corregida_q;
  assign simplerror_detectado = simplerror_q;
  assign doblerror_detectado  = doblerror_q;
  assign led_doblerror        = led_q;

endmodule

// File: tb/tb_hamming_secded_enlace.sv
// Directed and streamed checks of the SEC-DED link: reset, known vectors,
// and every single and double data-bit corruption pushed back to back.
module tb_hamming_secded_enlace;

  logic       reloj;
  logic       reinicio_n;
  logic [3:0] dato_entrada;
  logic [3:0] dato_error;
  logic [7:0] palabra;
  logic [7:0] recibido;
  logic       s1, s2, s3, st;
  logic       error_simple, error_doble;
  logic [3:0] corregido;
  logic [7:0] palabra_corregida;
  logic       simplerror_detectado, doblerror_detectado, led_doblerror;

  int errors = 0;
  int checks = 0;

  logic [3:0] q_d[$];
  logic [3:0] q_e[$];
  int         q_k[$];

  hamming_secded_enlace dut (
    .reloj               (reloj),
    .reinicio_n          (reinicio_n),
    .dato_entrada        (dato_entrada),
    .dato_error          (dato_error),
    .palabra             (palabra),
    .recibido            (recibido),
    .s1                  (s1),
    .s2                  (s2),
    .s3                  (s3),
    .st                  (st),
    .error_simple        (error_simple),
    .error_doble         (error_doble),
    .corregido           (corregido),
    .palabra_corregida   (palabra_corregida),
    .simplerror_detectado(simplerror_detectado),
    .doblerror_detectado (doblerror_detectado),
    .led_doblerror       (led_doblerror)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Bench-side encoder written position by position from the parity equations.
  function automatic logic [7:0] tb_encode(input logic [3:0] d);
    logic p1, p2, p3, p0;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    p0 = p1 ^ p2 ^ d[0] ^ p3 ^ d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1, p0};
  endfunction

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".palabra"}, palabra, 8'h00);
    check_eq({tag, ".recibido"}, recibido, 8'h00);
    check_eq({tag, ".syn_st"}, {4'h0, st, s3, s2, s1}, 8'h00);
    check_eq({tag, ".err"}, {6'h0, error_simple, error_doble}, 8'h00);
    check_eq({tag, ".corregido"}, {4'h0, corregido}, 8'h00);
    check_eq({tag, ".pcorr"}, palabra_corregida, 8'h00);
    check_eq({tag, ".flags"}, {5'h0, simplerror_detectado, doblerror_detectado, led_doblerror}, 8'h00);
  endtask

  // Holds one input pair for three edges and checks every stage against constants.
  task automatic directed(input string tag, input logic [3:0] d, input logic [3:0] e,
                          input logic [7:0] exp_pal, input logic [7:0] exp_rec,
                          input logic [2:0] exp_syn, input logic exp_st,
                          input logic [3:0] exp_corr, input logic [7:0] exp_pc,
                          input logic exp_se, input logic exp_de);
    dato_entrada = d;
    dato_error   = e;
    tick();
    check_eq({tag, ".palabra"}, palabra, exp_pal);
    tick();
    check_eq({tag, ".recibido"}, recibido, exp_rec);
    check_eq({tag, ".syn"}, {5'h0, s3, s2, s1}, {5'h0, exp_syn});
    check_eq({tag, ".st"}, {7'h0, st}, {7'h0, exp_st});
    check_eq({tag, ".err_stage2"}, {6'h0, error_simple, error_doble}, {6'h0, exp_se, exp_de});
    tick();
    check_eq({tag, ".corregido"}, {4'h0, corregido}, {4'h0, exp_corr});
    check_eq({tag, ".pcorr"}, palabra_corregida, exp_pc);
    check_eq({tag, ".flags"}, {5'h0, simplerror_detectado, doblerror_detectado, led_doblerror},
             {5'h0, exp_se, exp_de, exp_de});
    $display("txn %s d=%b e=%b corregido=%b se=%0b de=%0b", tag, d, e, corregido,
             simplerror_detectado, doblerror_detectado);
  endtask

  // Streams the queued vectors one per clock and checks each stage at its own latency.
  task automatic run_stream(input string tag);
    int n;
    n = q_d.size();
    for (int t = 0; t < n + 2; t++) begin
      if (t < n) begin
        dato_entrada = q_d[t];
        dato_error   = q_e[t];
      end else begin
        dato_entrada = 4'h0;
        dato_error   = 4'h0;
      end
      tick();
      if (t < n) begin
        check_eq({tag, ".palabra"}, palabra, tb_encode(q_d[t]));
      end
      if (t >= 1 && t - 1 < n) begin
        logic [7:0] pal;
        logic [3:0] e;
        pal = tb_encode(q_d[t-1]);
        e   = q_e[t-1];
        check_eq({tag, ".recibido"}, recibido, {e[3], e[2], e[1], pal[4], e[0], pal[2:0]});
      end
      if (t >= 2) begin
        int         i;
        logic [7:0] pal, rec;
        logic [3:0] e;
        i   = t - 2;
        pal = tb_encode(q_d[i]);
        e   = q_e[i];
        rec = {e[3], e[2], e[1], pal[4], e[0], pal[2:0]};
        if (q_k[i] == 1) begin
          check_eq({tag, ".corregido"}, {4'h0, corregido}, {4'h0, q_d[i]});
          check_eq({tag, ".pcorr"}, palabra_corregida, pal);
          check_eq({tag, ".flags"}, {5'h0, simplerror_detectado, doblerror_detectado, led_doblerror},
                   8'h04);
        end else begin
          check_eq({tag, ".corregido"}, {4'h0, corregido}, {4'h0, e});
          check_eq({tag, ".pcorr"}, palabra_corregida, rec);
          check_eq({tag, ".flags"}, {5'h0, simplerror_detectado, doblerror_detectado, led_doblerror},
                   8'h03);
        end
        $display("txn %s[%0d] d=%b e=%b corregido=%b se=%0b de=%0b", tag, i, q_d[i], e,
                 corregido, simplerror_detectado, doblerror_detectado);
      end
    end
  endtask

  initial begin
    reinicio_n   = 1'b0;
    dato_entrada = 4'h0;
    dato_error   = 4'h0;
    #3;
    check_all_zero("reset");
    #9;
    reinicio_n = 1'b1;

    directed("no_err", 4'b1010, 4'b1010, 8'hA5, 8'hA5, 3'b000, 1'b0, 4'b1010, 8'hA5, 1'b0, 1'b0);
    directed("single", 4'b0010, 4'b0000, 8'h33, 8'h13, 3'b101, 1'b1, 4'b0010, 8'h33, 1'b1, 1'b0);
    directed("double", 4'b1101, 4'b1011, 8'hCC, 8'hAC, 3'b011, 1'b0, 4'b1011, 8'hAC, 1'b0, 1'b1);

    for (int d = 0; d < 16; d++) begin
      for (int b = 0; b < 4; b++) begin
        q_d.push_back(4'(d));
        q_e.push_back(4'(d) ^ (4'b0001 << b));
        q_k.push_back(1);
      end
    end
    run_stream("single_stream");

    q_d.delete();
    q_e.delete();
    q_k.delete();
    for (int d = 0; d < 16; d++) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = i + 1; j < 4; j++) begin
          q_d.push_back(4'(d));
          q_e.push_back(4'(d) ^ (4'b0001 << i) ^ (4'b0001 << j));
          q_k.push_back(2);
        end
      end
    end
    run_stream("double_stream");

    // Load the pipeline with a double error, then reset between edges.
    dato_entrada = 4'b1101;
    dato_error   = 4'b1011;
    tick();
    tick();
    tick();
    check_eq("pre_reset.led", {7'h0, led_doblerror}, 8'h01);
    #2;
    reinicio_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    dato_entrada = 4'b1010;
    dato_error   = 4'b1010;
    #2;
    reinicio_n = 1'b1;
    tick();
    check_eq("refill.palabra", palabra, 8'hA5);
    tick();
    check_eq("refill.corregido_e2", {4'h0, corregido}, 8'h00);
    tick();
    check_eq("refill.corregido", {4'h0, corregido}, 8'h0A);
    check_eq("refill.flags", {5'h0, simplerror_detectado, doblerror_detectado, led_doblerror}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_secded_enlace.md
Name: hamming_secded_enlace

Overview:
- 4-bit SEC-DED Hamming link: encoder, channel-corruption injector, decoder and corrector in one 3-stage pipeline.
- Encodes `dato_entrada` into an 8-bit codeword (Hamming(7,4) plus overall parity).
- Substitutes `dato_error` for the data bits to model channel corruption, then computes the syndrome.
- Corrects single errors and flags double errors; drives an LED flag on double error.

Parameters:
- None. Widths are fixed: 4 data bits, 8-bit codeword.

Ports:
- `reloj` in 1: clock; all state updates on its rising edge.
- `reinicio_n` in 1: asynchronous active-low reset.
- `dato_entrada` in 4: data word to encode.
- `dato_error` in 4: data nibble as received from the channel; equal to `dato_entrada` means no corruption.
- `palabra` out 8: registered encoded codeword.
- `recibido` out 8: registered received codeword.
- `s1`, `s2`, `s3` out 1 each: registered Hamming syndrome bits.
- `st` out 1: registered overall-parity check bit.
- `error_simple` out 1: registered, single error detected at the decode stage.
- `error_doble` out 1: registered, double error detected at the decode stage.
- `corregido` out 4: corrected data nibble.
- `palabra_corregida` out 8: corrected codeword.
- `simplerror_detectado` out 1: single-error flag aligned with `corregido`.
- `doblerror_detectado` out 1: double-error flag aligned with `corregido`.
- `led_doblerror` out 1: LED drive, equal to `doblerror_detectado`.

Behaviour:
- Reset: while `reinicio_n`=0, every registered output is 0, asynchronously. The pipeline refills normally after release.
- Bit layout: `palabra[0]` = p0 (overall parity); `palabra[i]` = Hamming position i for i=1..7.
  - Position 1 = p1, 2 = p2, 4 = p3.
  - Position 3 = d[0], 5 = d[1], 6 = d[2], 7 = d[3].
- Parity equations:
  - p1 = d0^d1^d3
  - p2 = d0^d2^d3
  - p3 = d1^d2^d3
  - p0 = XOR of `palabra[7:1]` (even parity over all 8 bits).
- Stage 1 (edge k+1):
  - `palabra` <= encode(`dato_entrada`).
  - `dato_error` is captured into an internal register in the same cycle, so it stays paired with its codeword.
- Stage 2 (edge k+2):
  - `recibido` <= `palabra`, with positions 3,5,6,7 replaced by the stage-1 copy of `dato_error` bits 0,1,2,3. Parity bits are kept.
  - `s1` = XOR of `recibido` positions 1,3,5,7.
  - `s2` = XOR of positions 2,3,6,7.
  - `s3` = XOR of positions 4,5,6,7.
  - `st` = XOR of all 8 bits.
  - All of the above are computed combinationally from the new `recibido` and registered together with it.
  - `error_simple` = `st`.
  - `error_doble` = !`st` & ({`s3`,`s2`,`s1`} != 0).
- Stage 3 (edge k+3), with syn = {`s3`,`s2`,`s1`}:
  - Single error, syn != 0: flip `recibido` position syn.
  - Single error, syn = 0: flip bit 0 (p0).
  - Double error: no flip; `palabra_corregida` = `recibido`.
  - No error: pass `recibido` unchanged.
  - `corregido` = data positions {7,6,5,3} of `palabra_corregida`.
  - `simplerror_detectado` <= `error_simple`; `doblerror_detectado` <= `error_doble`; `led_doblerror` mirrors `doblerror_detectado`.
- Latency and throughput:
  - Input to `palabra`: 1 cycle.
  - Input to `recibido` and syndromes: 2 cycles.
  - Input to `corregido` and flags: 3 cycles.
  - Fully pipelined: one new word per cycle; no handshake; no stall.
- `simplerror_detectado` and `doblerror_detectado` are never both 1.
- More than two data-bit errors: no requirement beyond the equations above (aliasing is allowed).

Test Plan:
- Reset: assert `reinicio_n`=0 mid-stream -> all outputs 0 immediately. Release with `dato_entrada`=`dato_error`=1010 -> `corregido`=1010 three cycles later.
- No error: `dato_entrada`=1010, `dato_error`=1010 -> expect:
  - `palabra`=0xA5, `recibido`=0xA5
  - syn=000, `st`=0
  - `corregido`=1010
  - `simplerror_detectado`=0, `doblerror_detectado`=0, `led_doblerror`=0
- Single error: `dato_entrada`=0010, `dato_error`=0000 -> expect:
  - `palabra`=0x33, `recibido`=0x13
  - syn=101, `st`=1
  - `corregido`=0010, `palabra_corregida`=0x33
  - `simplerror_detectado`=1, `doblerror_detectado`=0
- Double error: `dato_entrada`=1101, `dato_error`=1011 -> expect:
  - `palabra`=0xCC, `recibido`=0xAC
  - syn=011, `st`=0
  - `corregido`=1011, `palabra_corregida`=0xAC
  - `simplerror_detectado`=0, `doblerror_detectado`=1, `led_doblerror`=1
- Exhaustive pipeline: stream all 16 data values, each paired with every 1-bit `dato_error` flip, one per cycle. At +3 cycles expect `corregido`=`dato_entrada` and `simplerror_detectado`=1 for every flip, with correct alignment and no bubbles.
- Exhaustive double flips: every 2-bit `dato_error` flip -> `doblerror_detectado`=1, `simplerror_detectado`=0, `palabra_corregida`=`recibido`.
